oled_spi_arbiter: RTL and testbench
===================================

Name: oled_spi_arbiter

Overview:
- Shares the single OLED SPI byte writer between N requesters: the init sequencer on port 0, plus draw and scroll engines on the other ports.
- Every requester uses the same level handshake: hold START high with DATA stable, then drop START one cycle after seeing DONE.
- Round-robin grant, with an optional LOCK so a command byte and its argument bytes go out back-to-back without interleaving.
- Ports other than 0 are blocked until the init sequence reports done.

Parameters:
- N, 3, number of requesters (2..8); port 0 is the init sequencer.
- DATA_W, 10, writer word width: {2-bit control prefix, 8-bit byte}.
- LOCK_TIMEOUT, 16'd1000, idle cycles a locked owner may hold the grant without a new START before it is force-released.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- INIT_DONE  input  1  init sequence complete; until high, only port 0 is eligible
- REQ_START  input  N  per-requester write request, level, held until DONE
- REQ_DATA  input  N*DATA_W  per-requester word; slice i = [i*DATA_W +: DATA_W]
- REQ_LOCK  input  N  owner wants to keep the grant after the current word
- REQ_DONE  output  N  one-cycle pulse to the owner when its word completes
- GRANT  output  N  one-hot current owner; zero when no owner
- SPI_START  output  1  to writer WRITE_START
- SPI_DATA  output  DATA_W  to writer DATA
- SPI_DONE  input  1  writer WRITE_DONE, one-cycle pulse

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE; GRANT=0, REQ_DONE=0, SPI_START=0, SPI_DATA=0; rr pointer=0; timeout counter=0.
  - Reset mid-transfer aborts it and issues no REQ_DONE; the writer is reset by the same RST.
- Eligibility: elig = REQ_START & (INIT_DONE ? all ones : 1 at bit 0 only).
- IDLE:
  - If elig != 0, pick the first set bit searching from the rr pointer upward with wrap.
  - Register owner, set GRANT one-hot, latch the owner's REQ_DATA slice into SPI_DATA, set SPI_START=1, go to XFER.
  - Latency from REQ_START to SPI_START is 1 cycle.
- XFER:
  - SPI_START and SPI_DATA are held constant; REQ_DATA changes are ignored.
  - On SPI_DONE: SPI_START=0, REQ_DONE[owner]=1 for exactly one cycle, capture lock_q=REQ_LOCK[owner], go to RELEASE.
- RELEASE (1 cycle; REQ_START is ignored to absorb the requester's drop latency):
  - If lock_q, go to LOCKED and clear the timeout counter.
  - Else clear GRANT, set rr pointer = owner+1 mod N, go to IDLE.
- LOCKED (GRANT stays on the owner; other requests wait):
  - If REQ_START[owner]: latch data, SPI_START=1, go to XFER.
  - Else if REQ_LOCK[owner]=0, or the counter reaches LOCK_TIMEOUT: release as in RELEASE-unlocked.
  - Otherwise increment the counter.
  - START has priority over LOCK deassertion in the same cycle.
- Simultaneous requests in IDLE: exactly one grant per cycle, round-robin fair; the same owner cannot win twice in a row unless it is the only requester or uses LOCK.
- INIT_DONE falling while another port owns the bus: the current word and lock continue; the gate applies only to new grants.
- SPI_DONE outside XFER is ignored.
- Invariants: GRANT is always zero or one-hot; REQ_DONE is only ever asserted on the GRANT bit.

Decomposition:
- Shared package oled_pkg:
  - OLED_DATA_W=10.
  - Prefix constants OLED_CMD=2'b00, OLED_DAT=2'b01.
  - Arbiter state encoding (IDLE, XFER, RELEASE, LOCKED).
- One sub-module, oled_rr_pick: combinational round-robin first-set search.
  - Inputs: elig, pointer.
  - Outputs: one-hot grant and index.
  - Reused later by the frame-buffer port arbiter.

Test Plan:
- Single request: RST then INIT_DONE=1; port 1 raises START with {00,8'hAE}; writer model returns SPI_DONE 8 cycles later. Required: SPI_START rises 1 cycle after REQ_START, SPI_DATA=0x0AE, REQ_DONE[1] pulses once, GRANT returns to 0 two cycles after SPI_DONE.
- Init gating: INIT_DONE=0, ports 0 and 2 request together. Required: only port 0 is granted, and port 2 stays waiting until INIT_DONE=1.
- Round-robin: ports 0, 1 and 2 request continuously with INIT_DONE=1. Required: grants go 0,1,2,0,1,2 and every REQ_DONE lands on the matching port.
- Locked burst: port 1 sends 0x81 with LOCK=1, then 0xFF with LOCK=0, while port 2 requests throughout. Required: SPI_DATA sequence is 0x081, 0x0FF, then port 2's word; port 2 is never granted in between.
- Lock timeout: port 1 completes a word with LOCK=1, then stays idle. Required: GRANT[1] is released after LOCK_TIMEOUT=1000 cycles and port 2 is granted on the next IDLE cycle.
- Reset mid-XFER: assert RST for 1 cycle while SPI_START=1. Required: next cycle SPI_START=0, GRANT=0, no REQ_DONE pulse.

Source files
------------

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared OLED word format and arbiter state encoding
// Purpose: constants and types shared by the OLED SPI arbiter and its helpers.
//   OLED_DATA_W      writer word width, {2-bit control prefix, 8-bit byte}
//   OLED_CMD/OLED_DAT control prefixes for command and data bytes
//   arb_state_e      arbiter FSM states
package oled_pkg;

    localparam int OLED_DATA_W = 10;

    localparam logic [1:0] OLED_CMD = 2'b00;
    localparam logic [1:0] OLED_DAT = 2'b01;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_XFER    = 2'd1,
        ARB_RELEASE = 2'd2,
        ARB_LOCKED  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/oled_rr_pick.sv
// rtl/oled_rr_pick.sv - combinational round-robin first-set search
// Purpose: picks the first eligible requester at or above the pointer, with wrap.
// Ports:
//   elig_i   [N-1:0]      eligible requesters
//   ptr_i    [IDX_W-1:0]  search start position (must be < N)
//   grant_o  [N-1:0]      one-hot winner, zero when nothing is eligible
//   idx_o    [IDX_W-1:0]  winner index, zero when nothing is eligible
module oled_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        logic found;
        int   j;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && elig_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// rtl/oled_spi_arbiter.sv - round-robin arbiter sharing one OLED SPI byte writer
// Purpose: grants the SPI writer to one of N requesters per word, with optional
//   lock for multi-byte commands and init gating (only port 0 before INIT_DONE).
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   INIT_DONE         init sequence finished; ports 1..N-1 eligible only when high
//   REQ_START[N]      level request, held until REQ_DONE
//   REQ_DATA[N*DW]    per-port word, slice i = [i*DATA_W +: DATA_W]
//   REQ_LOCK[N]       owner keeps the grant after the current word
//   REQ_DONE[N]       one-cycle completion pulse to the owner
//   GRANT[N]          one-hot current owner, zero when free
//   SPI_START/SPI_DATA/SPI_DONE  writer handshake
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int          N            = 3,
    parameter int          DATA_W       = OLED_DATA_W,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd1000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                INIT_DONE,
    input  logic [N-1:0]        REQ_START,
    input  logic [N*DATA_W-1:0] REQ_DATA,
    input  logic [N-1:0]        REQ_LOCK,
    output logic [N-1:0]        REQ_DONE,
    output logic [N-1:0]        GRANT,
    output logic                SPI_START,
    output logic [DATA_W-1:0]   SPI_DATA,
    input  logic                SPI_DONE
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    arb_state_e         state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N-1:0]       done_q, done_d;
    logic               start_q, start_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               lock_q, lock_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [N-1:0]       gate;
    logic [N-1:0]       elig;
    logic [N-1:0]       pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  pick_word;
    logic [DATA_W-1:0]  own_word;
    logic [IDX_W-1:0]   rr_next;
    logic               own_start;
    logic               own_lock;

    // Before init completes only the init sequencer (port 0) may win.
    assign gate = INIT_DONE ? {N{1'b1}} : {{(N-1){1'b0}}, 1'b1};
    assign elig = REQ_START & gate;

    oled_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig_i  (elig),
        .ptr_i   (rr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Word muxes driven by one-hot vectors so no index can fall outside 0..N-1.
    always_comb begin
        pick_word = '0;
        own_word  = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_grant[i]) pick_word = REQ_DATA[i*DATA_W +: DATA_W];
            if (grant_q[i])    own_word  = REQ_DATA[i*DATA_W +: DATA_W];
        end
    end

    assign own_start = |(REQ_START & grant_q);
    assign own_lock  = |(REQ_LOCK & grant_q);
    assign rr_next   = (owner_q == IDX_W'(N-1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        done_d  = '0;
        start_d = start_q;
        data_d  = data_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (|elig) begin
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                    data_d  = pick_word;
                    start_d = 1'b1;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (SPI_DONE) begin
                    start_d = 1'b0;
                    done_d  = grant_q;
                    lock_d  = own_lock;
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                // REQ_START is still high here while the owner reacts to DONE.
                if (lock_q) begin
                    cnt_d   = '0;
                    state_d = ARB_LOCKED;
                end else begin
                    grant_d = '0;
                    rr_d    = rr_next;
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (own_start) begin
                    data_d  = own_word;
                    start_d = 1'b1;
                    state_d = ARB_XFER;
                end else if (!own_lock || (cnt_q == LOCK_TIMEOUT)) begin
                    grant_d = '0;
                    rr_d    = rr_next;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            rr_q    <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            start_q <= start_d;
            data_q  <= data_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GRANT     = grant_q;
    assign REQ_DONE  = done_q;
    assign SPI_START = start_q;
    assign SPI_DATA  = data_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// tb/tb_oled_spi_arbiter.sv - self-checking bench for oled_spi_arbiter
module tb_oled_spi_arbiter;
    import oled_pkg::*;

    localparam int N  = 3;
    localparam int DW = OLED_DATA_W;
    localparam int LT = 1000;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_done;
    logic [N-1:0]    req_start;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_done;
    logic [N-1:0]    grant;
    logic            spi_start;
    logic [DW-1:0]   spi_data;
    logic            spi_done;

    always #5 clk = ~clk;

    oled_spi_arbiter #(
        .N            (N),
        .DATA_W       (DW),
        .LOCK_TIMEOUT (16'(LT))
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .INIT_DONE (init_done),
        .REQ_START (req_start),
        .REQ_DATA  (req_data),
        .REQ_LOCK  (req_lock),
        .REQ_DONE  (req_done),
        .GRANT     (grant),
        .SPI_START (spi_start),
        .SPI_DATA  (spi_data),
        .SPI_DONE  (spi_done)
    );

    typedef struct { logic [DW-1:0] data; logic lock; } word_t;
    typedef struct { int port; logic [DW-1:0] data; } exp_t;
    typedef struct { logic init; int port; logic [DW-1:0] data; logic blocked; } vec_t;

    word_t pq[N][$];
    exp_t  exp_q[$];
    logic  active[N];
    int    done_cnt[N];
    int    total_done = 0;
    int    wcnt = 0;
    int    wr_delay = 8;
    logic  prev_ss = 1'b0;
    logic  spur = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One cycle: observe outputs at the falling edge, then run the writer
    // model and the requester models, whose drives land on the next rising edge.
    task automatic tick();
        exp_t  e;
        word_t w;
        logic  rise;
        @(negedge clk);
        check("grant_onehot", 32'(($countones(grant) > 1) ? 1 : 0), 32'd0);
        if (req_done != '0) begin
            check("done_on_grant", 32'(req_done), 32'(grant));
            total_done++;
        end
        rise = spi_start && !prev_ss;
        if (rise) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start actual data=0x%0h grant=0x%0h required=no start",
                         spi_data, grant);
            end else begin
                e = exp_q.pop_front();
                check("start_data", 32'(spi_data), 32'(e.data));
                check("start_grant", 32'(grant), 32'd1 << e.port);
            end
        end
        prev_ss = spi_start;
        if (spi_start) wcnt = rise ? 0 : wcnt + 1;
        spi_done = spur || (spi_start && (wcnt == wr_delay - 1));
        for (int i = 0; i < N; i++) begin
            if (active[i] && req_done[i]) begin
                req_start[i] = 1'b0;
                active[i]    = 1'b0;
                done_cnt[i]++;
            end else if (!active[i] && pq[i].size() > 0) begin
                w = pq[i].pop_front();
                req_start[i]            = 1'b1;
                req_data[i*DW +: DW]    = w.data;
                req_lock[i]             = w.lock;
                active[i]               = 1'b1;
            end
        end
    endtask

    task automatic clear_requesters();
        req_start = '0;
        req_lock  = '0;
        req_data  = '0;
        spur      = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0;
            pq[i].delete();
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_requesters();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int p, input logic [DW-1:0] d, input logic lk, input logic expect_it);
        pq[p].push_back('{data: d, lock: lk});
        if (expect_it) exp_q.push_back('{port: p, data: d});
    endtask

    task automatic wait_done(input int p, input int target, input string name);
        for (int k = 0; k < 200 && done_cnt[p] < target; k++) tick();
        check(name, 32'(done_cnt[p]), 32'(target));
    endtask

    vec_t vecs[6];

    initial begin
        int held;
        int td;
        int tgt;
        rst       = 1'b1;
        init_done = 1'b0;
        spi_done  = 1'b0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;

        vecs[0] = '{1'b1, 0, {OLED_DAT, 8'h3C}, 1'b0};
        vecs[1] = '{1'b1, 2, {OLED_CMD, 8'hA1}, 1'b0};
        vecs[2] = '{1'b0, 0, {OLED_CMD, 8'hAF}, 1'b0};
        vecs[3] = '{1'b0, 1, {OLED_DAT, 8'h55}, 1'b1};
        vecs[4] = '{1'b0, 2, {OLED_DAT, 8'hC3}, 1'b1};
        vecs[5] = '{1'b1, 1, {OLED_DAT, 8'hFF}, 1'b0};

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_spi_data", 32'(spi_data), 32'd0);

        // Single request: latency and release timing
        init_done = 1'b1;
        push(1, {OLED_CMD, 8'hAE}, 1'b0, 1'b1);
        tick();
        check("lat_before", 32'(spi_start), 32'd0);
        tick();
        check("lat_start", 32'(spi_start), 32'd1);
        for (int k = 0; k < 50 && !spi_done; k++) tick();
        check("single_spi_done_seen", 32'(spi_done), 32'd1);
        tick();
        check("single_req_done", 32'(req_done), 32'b010);
        check("single_grant_release", 32'(grant), 32'b010);
        tick();
        check("single_grant_zero", 32'(grant), 32'd0);
        check("single_done_once", 32'(req_done), 32'd0);

        // Table-driven single transfers, including init gating
        for (int v = 0; v < 6; v++) begin
            init_done = vecs[v].init;
            tgt = done_cnt[vecs[v].port] + 1;
            push(vecs[v].port, vecs[v].data, 1'b0, !vecs[v].blocked);
            if (vecs[v].blocked) begin
                repeat (20) tick();
                check("vec_gate_grant", 32'(grant), 32'd0);
                check("vec_gate_done", 32'(done_cnt[vecs[v].port]), 32'(tgt - 1));
                exp_q.push_back('{port: vecs[v].port, data: vecs[v].data});
                init_done = 1'b1;
            end
            wait_done(vecs[v].port, tgt, "vec_done");
            repeat (3) tick();
        end
        check("vec_sb_empty", 32'(exp_q.size()), 32'd0);

        // Init gating with simultaneous requests from ports 0 and 2
        do_reset();
        init_done = 1'b0;
        push(0, {OLED_CMD, 8'h8D}, 1'b0, 1'b1);
        push(2, {OLED_DAT, 8'h77}, 1'b0, 1'b0);
        wait_done(0, done_cnt[0] + 1, "gate_p0_done");
        repeat (20) tick();
        check("gate_p2_waiting", 32'(grant), 32'd0);
        exp_q.push_back('{port: 2, data: {OLED_DAT, 8'h77}});
        init_done = 1'b1;
        wait_done(2, done_cnt[2] + 1, "gate_p2_done");

        // Round-robin with three continuous requesters
        do_reset();
        init_done = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++)
                pq[p].push_back('{data: DW'(16 * r + p + 1), lock: 1'b0});
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++)
                exp_q.push_back('{port: p, data: DW'(16 * r + p + 1)});
        for (int k = 0; k < 300 && (exp_q.size() > 0 || req_start != '0); k++) tick();
        check("rr_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rr_idle", 32'(req_start), 32'd0);

        // Locked burst with port 2 competing
        do_reset();
        td = done_cnt[2];
        push(1, {OLED_CMD, 8'h81}, 1'b1, 1'b1);
        push(1, {OLED_CMD, 8'hFF}, 1'b0, 1'b1);
        push(2, {OLED_DAT, 8'h3A}, 1'b0, 1'b1);
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) tick();
        check("burst_sb_empty", 32'(exp_q.size()), 32'd0);
        wait_done(2, td + 1, "burst_p2_done");

        // Lock timeout: owner idles with LOCK held
        do_reset();
        push(1, {OLED_CMD, 8'hA5}, 1'b1, 1'b1);
        push(2, {OLED_DAT, 8'h5A}, 1'b0, 1'b1);
        wait_done(1, done_cnt[1] + 1, "to_p1_done");
        held = 0;
        for (int k = 0; k < LT + 50; k++) begin
            tick();
            if (grant[1]) held++;
            else break;
        end
        // RELEASE hands over to LOCKED with counter 0; release happens on the
        // cycle the counter equals LT, i.e. LT+1 LOCKED cycles.
        check("to_hold_cycles", 32'(held), 32'(LT + 1));
        check("to_released", 32'(grant), 32'd0);
        tick();
        check("to_p2_granted", 32'(grant), 32'b100);
        req_lock[1] = 1'b0;
        wait_done(2, done_cnt[2] + 1, "to_p2_done");

        // SPI_DONE outside XFER is ignored
        repeat (3) tick();
        td = total_done;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (3) tick();
        check("spur_no_done", 32'(total_done), 32'(td));
        check("spur_grant", 32'(grant), 32'd0);

        // Reset in the middle of a transfer
        do_reset();
        push(1, {OLED_DAT, 8'h42}, 1'b0, 1'b1);
        for (int k = 0; k < 20 && !spi_start; k++) tick();
        check("mid_started", 32'(spi_start), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        clear_requesters();
        tick();
        check("mid_spi_start", 32'(spi_start), 32'd0);
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_done", 32'(req_done), 32'd0);
        rst = 1'b0;
        td = total_done;
        repeat (15) tick();
        check("mid_no_done", 32'(total_done), 32'(td));
        check("mid_idle", 32'(spi_start), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
